// File: rtl/gcn_combination_if.sv
//------------------------------------------------------------------------------
// Module      : gcn_combination_if
// Description : Feature, weight-load and result bundle of the GCN combination stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface gcn_combination_if #(
    parameter int AGGR_OUT_SIZE = 7,
    parameter int WEIGHT_SIZE   = 4,
    parameter int COMB_OUT_SIZE = 8
) ();
    logic                       in_ready_comb;
    logic [16*AGGR_OUT_SIZE-1:0] feat_in;
    logic                       w_wr_en;
    logic [2:0]                 w_addr;
    logic [WEIGHT_SIZE-1:0]     w_data;
    logic                       busy;
    logic                       out_ready_comb;
    logic [8*COMB_OUT_SIZE-1:0] y_out;
    logic                       overrun;

    modport master (
        output in_ready_comb, feat_in, w_wr_en, w_addr, w_data,
        input  busy, out_ready_comb, y_out, overrun
    );

    modport slave (
        input  in_ready_comb, feat_in, w_wr_en, w_addr, w_data,
        output busy, out_ready_comb, y_out, overrun
    );
endinterface

`default_nettype wire

// File: rtl/gcn_combination.sv
//------------------------------------------------------------------------------
// Module      : gcn_combination
// Description : 4-node x 4-feature by 4x2 weight multiply, 4 parallel MACs over
//               8 cycles, saturated outputs. Optional ReLU via COMB_RELU_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gcn_combination #(
    parameter int AGGR_OUT_SIZE = 7,
    parameter int WEIGHT_SIZE   = 4,
    parameter int COMB_OUT_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst,
    gcn_combination_if.slave   bus
);
    localparam int PROD_W = AGGR_OUT_SIZE + WEIGHT_SIZE;
    localparam int ACC_W  = PROD_W + 2;
    localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'((1 <<< (COMB_OUT_SIZE - 1)) - 1);
    localparam logic signed [ACC_W-1:0] c_sat_min = ~c_sat_max;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic [2:0]                        cnt_q;
    logic [16*AGGR_OUT_SIZE-1:0]       x_q;
    logic signed [ACC_W-1:0]           acc_q [4];
    logic [COMB_OUT_SIZE-1:0]          hold_q [8];
    logic signed [WEIGHT_SIZE-1:0]     w_q [8];
    logic [8*COMB_OUT_SIZE-1:0]        y_q;
    logic                              ready_q;
    logic                              busy_q, busy_d;
    logic                              overrun_q;
    logic signed [ACC_W-1:0]           sum_w [4];
    logic signed [WEIGHT_SIZE-1:0]     w_sel;

    function automatic logic [COMB_OUT_SIZE-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
        logic [COMB_OUT_SIZE-1:0] r;
        if (v > c_sat_max)
            r = c_sat_max[COMB_OUT_SIZE-1:0];
        else if (v < c_sat_min)
            r = c_sat_min[COMB_OUT_SIZE-1:0];
        else
            r = v[COMB_OUT_SIZE-1:0];
`ifdef COMB_RELU_EN
        if (r[COMB_OUT_SIZE-1])
            r = '0;
`endif
        return r;
    endfunction

    // Weight address {o,f} coincides with the step counter, so cnt indexes W directly
    assign w_sel = w_q[cnt_q];

    for (genvar n = 0; n < 4; n++) begin : g_node
        logic signed [AGGR_OUT_SIZE-1:0] x_sel;
        logic signed [PROD_W-1:0]        prod;
        assign x_sel    = x_q[(n*4 + int'(cnt_q[1:0]))*AGGR_OUT_SIZE +: AGGR_OUT_SIZE];
        assign prod     = x_sel * w_sel;
        assign sum_w[n] = acc_q[n] + ACC_W'(prod);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_ready_comb) state_d = S_ACC;
            S_ACC:   if (cnt_q == 3'd7)     state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // busy stays up through the result cycle so it falls one edge after DONE
        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int n = 0; n < 4; n++) acc_q[n]  <= '0;
            for (int k = 0; k < 8; k++) hold_q[k] <= '0;
            for (int k = 0; k < 8; k++) w_q[k]    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            ready_q <= 1'b0;
            if (bus.in_ready_comb && state_q != S_IDLE)
                overrun_q <= 1'b1;
            if (bus.w_wr_en && state_q == S_IDLE)
                w_q[bus.w_addr] <= bus.w_data;
            case (state_q)
                S_IDLE: begin
                    if (bus.in_ready_comb) begin
                        x_q   <= bus.feat_in;
                        cnt_q <= '0;
                        for (int n = 0; n < 4; n++) acc_q[n] <= '0;
                    end
                end
                S_ACC: begin
                    for (int n = 0; n < 4; n++) begin
                        if (cnt_q[1:0] == 2'd3) begin
                            hold_q[{n[1:0], cnt_q[2]}] <= sat_fn(sum_w[n]);
                            acc_q[n] <= '0;
                        end else begin
                            acc_q[n] <= sum_w[n];
                        end
                    end
                    cnt_q <= cnt_q + 3'd1;
                end
                S_DONE: begin
                    for (int k = 0; k < 8; k++) y_q[k*COMB_OUT_SIZE +: COMB_OUT_SIZE] <= hold_q[k];
                    ready_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.out_ready_comb = ready_q;
    assign bus.y_out          = y_q;
    assign bus.overrun        = overrun_q;

endmodule

`default_nettype wire

// File: doc/gcn_combination.md
# gcn_combination

Combination stage of the GCN datapath, directly downstream of the neighbour-aggregation stage. It captures the 16 aggregated features (4 features × 4 nodes) on a ready pulse and multiplies each node's feature vector by a loadable 4×2 signed weight matrix. It uses 4 node-parallel MACs over 8 sequential cycles, saturates each result to the output width, and emits 8 node outputs with a one-cycle ready pulse.

## Interface
- `AGGR_OUT_SIZE`, 7: signed width of each aggregated input feature.
- `WEIGHT_SIZE`, 4: signed width of each weight.
- `COMB_OUT_SIZE`, 8: signed width of each output; results saturate to this width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_ready_comb` in 1: one-cycle pulse; `feat_in` is valid in the same cycle.
- `feat_in` in 16*AGGR_OUT_SIZE: packed features; `feat_in[(n*4+f)*AGGR_OUT_SIZE +: AGGR_OUT_SIZE]` = feature f of node n.
- `w_wr_en` in 1: weight write strobe.
- `w_addr` in 3: weight index; `{o, f}` where `o = w_addr[2]` and `f = w_addr[1:0]`.
- `w_data` in WEIGHT_SIZE: signed weight value.
- `busy` out 1: high while a computation is in flight.
- `out_ready_comb` out 1: one-cycle pulse when `y_out` is updated.
- `y_out` out 8*COMB_OUT_SIZE: packed results; `y_out[(n*2+o)*COMB_OUT_SIZE +: COMB_OUT_SIZE]` = output o of node n; held between updates.
- `overrun` out 1: sticky flag, set when `in_ready_comb` arrives while busy; cleared only by `rst`.

## Operation
- Math: y[n][o] = sat( Σ_{f=0..3} x[n][f] · W[f][o] ).
  - Product width: AGGR_OUT_SIZE+WEIGHT_SIZE.
  - Accumulator width: AGGR_OUT_SIZE+WEIGHT_SIZE+2 (13 bits at defaults); no overflow is possible.
- Saturation clamps to [−2^(COMB_OUT_SIZE−1), 2^(COMB_OUT_SIZE−1)−1].
- Weight bank: 8 registers.
  - A write occurs when `w_wr_en` is high and the FSM is in IDLE.
  - Writes while busy are dropped silently.
- FSM states: IDLE, ACC, DONE.
  - IDLE: if `in_ready_comb` is high, latch `feat_in` into the capture register, clear the 4 accumulators, set cnt=0, go to ACC.
  - ACC: each cycle, for all 4 nodes in parallel, acc[n] += x[n][cnt[1:0]] · W[cnt[1:0]][cnt[2]].
    - When cnt[1:0]==3, the saturated acc[n] is written into holding slot o=cnt[2] and the accumulator clears.
    - cnt==7 → DONE; otherwise cnt increments.
  - DONE: copy all 8 holding slots to `y_out`, pulse `out_ready_comb`, return to IDLE.
- Rules when not in IDLE:
  - `in_ready_comb` in ACC or DONE: the pulse is ignored and `overrun` is set.
  - The frame in flight is unaffected.
- Simultaneous `w_wr_en` and `in_ready_comb` in IDLE: the write commits at that edge, and the new frame uses the new weight.
- Reset:
  - `y_out`, the holding slots, the weights, `out_ready_comb`, `busy` and `overrun` all go to 0; state goes to IDLE.
  - Reset mid-frame aborts the frame: no `out_ready_comb` is produced, and `y_out` reads zero.

## Timing
- Edge E0 samples `in_ready_comb`=1 in IDLE. `busy`=1 from after E0.
- Edges E1–E8 perform the 8 ACC steps.
- Edge E9 (DONE) registers `y_out` and sets `out_ready_comb`=1 for exactly one cycle.
- Latency: `out_ready_comb` is high in the cycle following E9, i.e. 10 edges after the input pulse, counting the sampling edge.
- `busy` drops at E10. A new pulse at E10 is accepted.
- Throughput: 1 frame per 10 cycles.
- `y_out` changes only together with `out_ready_comb`.

## Configuration
- `COMB_RELU_EN`:
  - Defined: max(0, ·) is applied after saturation, so negative results become 0.
  - Undefined: signed saturated values are passed through.
- The macro does not change the width, the latency or any other behaviour.

## Test plan
- Dot product: W[f][0]=+1, W[f][1]=−1 for all f; x[n][f]=f+n.
  - Pulse `in_ready_comb` → after 10 edges, one `out_ready_comb` pulse.
  - Node 0 = (6, −6); node 3 = (18, −18).
- Saturation: all weights 7.
  - All x=63 → every output 127.
  - All x=−64 → every output −128.
- Overrun: pulse `in_ready_comb` at E0 and again at E4.
  - Only one `out_ready_comb` pulse (cycle after E9); results come from the first frame.
  - `overrun`=1 and stays 1.
- Weight write while busy: write W[0][0]=5 during ACC → dropped; the next frame still uses the old weight.
  - Simultaneous write and `in_ready_comb` in IDLE → the new weight is used.
- Reset at E5 mid-frame: no `out_ready_comb`; `y_out`=0, `busy`=0, all weights 0.
  - The next frame yields all-zero outputs.
- With `COMB_RELU_EN` defined: scenario 1 gives node 0 = (6, 0) and node 3 = (18, 0).
